// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-style write-then-read self test for a single-port RAM.
// Writes exp(a) = a + seed to every word, reads every word back through a
// one-stage compare pipeline and reports pass / error count / first fail.
// Optional build macro: RAM_BIST_INVERT_PASS_EN adds a second pass that uses
// the bitwise-inverted pattern, accumulating into the same error results.
module ram_bist_ctrl #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 256,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWIDTH-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [AWIDTH-1:0] fail_addr,
  output logic              ram_wr_en,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wr_data,
  input  logic [DWIDTH-1:0] ram_rd_data
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [AWIDTH-1:0] CNT_LAST = AWIDTH'(DEPTH - 1);

  // Test pattern: low DWIDTH bits of the address plus seed, optionally inverted.
  function automatic logic [DWIDTH-1:0] pat_fn(
    input logic [AWIDTH-1:0] a,
    input logic [DWIDTH-1:0] s,
    input logic              inv
  );
    logic [AWIDTH+DWIDTH-1:0] a_ext;
    logic [DWIDTH-1:0]        v;
    a_ext  = {{DWIDTH{1'b0}}, a};
    v      = a_ext[DWIDTH-1:0] + s;
    pat_fn = inv ? ~v : v;
  endfunction

  state_t              state_r, state_nxt;
  logic [AWIDTH-1:0]   cnt_r, cnt_nxt;
  logic [DWIDTH-1:0]   seed_r, seed_nxt;
  logic                accept_s;

  // compare pipeline: address/expected of the word whose read data arrives next cycle
  logic                pv_r, pv_nxt;
  logic [AWIDTH-1:0]   pa_r, pa_nxt;
  logic [DWIDTH-1:0]   pe_r, pe_nxt;
  logic                mismatch_s;

  logic [15:0]         err_cnt_r, err_cnt_nxt;
  logic [AWIDTH-1:0]   fail_addr_r, fail_addr_nxt;
  logic                first_fail_r, first_fail_nxt;
  logic                pass_r, pass_nxt;

  logic                busy_r, busy_nxt;
  logic                done_r, done_nxt;
  logic                wr_en_r, wr_en_nxt;
  logic [AWIDTH-1:0]   addr_r, addr_nxt;
  logic [DWIDTH-1:0]   wdata_r, wdata_nxt;

  logic                pidx_s, pidx_nxt_s;

`ifdef RAM_BIST_INVERT_PASS_EN
  logic                pidx_r;

  // Pass-index register: 0 = true pattern, 1 = inverted pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pidx_r <= 1'b0;
    end else begin
      pidx_r <= pidx_nxt_s;
    end
  end

  assign pidx_s = pidx_r;
`else
  assign pidx_s     = 1'b0;
  assign pidx_nxt_s = 1'b0;
`endif

  // Next-state, address counter, seed latch and pass sequencing.
  always_comb begin
    state_nxt  = state_r;
    cnt_nxt    = cnt_r;
    seed_nxt   = seed_r;
    accept_s   = 1'b0;
`ifdef RAM_BIST_INVERT_PASS_EN
    pidx_nxt_s = pidx_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s   = 1'b1;
          seed_nxt   = seed;
          cnt_nxt    = '0;
          state_nxt  = ST_WRITE;
`ifdef RAM_BIST_INVERT_PASS_EN
          pidx_nxt_s = 1'b0;
`endif
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_READ;
        end else begin
          cnt_nxt   = cnt_r + AWIDTH'(1);
        end
      end
      ST_READ: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_DRAIN;
        end else begin
          cnt_nxt   = cnt_r + AWIDTH'(1);
        end
      end
      ST_DRAIN: begin
`ifdef RAM_BIST_INVERT_PASS_EN
        if (!pidx_r) begin
          pidx_nxt_s = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = ST_WRITE;
        end else begin
          state_nxt  = ST_DONE;
        end
`else
        state_nxt = ST_DONE;
`endif
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Compare stage and result bookkeeping (error count, first fail, pass flag).
  always_comb begin
    pv_nxt         = 1'b0;
    pa_nxt         = '0;
    pe_nxt         = '0;
    err_cnt_nxt    = err_cnt_r;
    fail_addr_nxt  = fail_addr_r;
    first_fail_nxt = first_fail_r;
    pass_nxt       = pass_r;
    mismatch_s     = pv_r && (ram_rd_data != pe_r);
    if (state_r == ST_READ) begin
      pv_nxt = 1'b1;
      pa_nxt = cnt_r;
      pe_nxt = pat_fn(cnt_r, seed_r, pidx_s);
    end else begin
      pv_nxt = 1'b0;
    end
    if (accept_s) begin
      err_cnt_nxt    = 16'h0000;
      fail_addr_nxt  = '0;
      first_fail_nxt = 1'b0;
      pass_nxt       = 1'b0;
    end else begin
      if (mismatch_s) begin
        if (err_cnt_r != 16'hFFFF) begin
          err_cnt_nxt = err_cnt_r + 16'd1;
        end else begin
          err_cnt_nxt = err_cnt_r;
        end
        if (!first_fail_r) begin
          first_fail_nxt = 1'b1;
          fail_addr_nxt  = pa_r;
        end else begin
          fail_addr_nxt  = fail_addr_r;
        end
      end else begin
        err_cnt_nxt = err_cnt_r;
      end
      // the final compare lands on the same edge that enters DONE
      if (state_nxt == ST_DONE) begin
        pass_nxt = (err_cnt_nxt == 16'h0000);
      end else begin
        pass_nxt = pass_r;
      end
    end
  end

  // Output decode from the next state so the RAM port and flags are flop outputs.
  always_comb begin
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    wr_en_nxt = 1'b0;
    addr_nxt  = '0;
    wdata_nxt = '0;
    case (state_nxt)
      ST_WRITE: begin
        busy_nxt  = 1'b1;
        wr_en_nxt = 1'b1;
        addr_nxt  = cnt_nxt;
        wdata_nxt = pat_fn(cnt_nxt, seed_nxt, pidx_nxt_s);
      end
      ST_READ: begin
        busy_nxt = 1'b1;
        addr_nxt = cnt_nxt;
      end
      ST_DRAIN: begin
        busy_nxt = 1'b1;
      end
      ST_DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any test in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      seed_r       <= '0;
      pv_r         <= 1'b0;
      pa_r         <= '0;
      pe_r         <= '0;
      err_cnt_r    <= 16'h0000;
      fail_addr_r  <= '0;
      first_fail_r <= 1'b0;
      pass_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      wr_en_r      <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
    end else begin
      state_r      <= state_nxt;
      cnt_r        <= cnt_nxt;
      seed_r       <= seed_nxt;
      pv_r         <= pv_nxt;
      pa_r         <= pa_nxt;
      pe_r         <= pe_nxt;
      err_cnt_r    <= err_cnt_nxt;
      fail_addr_r  <= fail_addr_nxt;
      first_fail_r <= first_fail_nxt;
      pass_r       <= pass_nxt;
      busy_r       <= busy_nxt;
      done_r       <= done_nxt;
      wr_en_r      <= wr_en_nxt;
      addr_r       <= addr_nxt;
      wdata_r      <= wdata_nxt;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign err_cnt     = err_cnt_r;
  assign fail_addr   = fail_addr_r;
  assign ram_wr_en   = wr_en_r;
  assign ram_addr    = addr_r;
  assign ram_wr_data = wdata_r;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: a DEPTH=16 instance with a fault-injecting
// RAM model and a DEPTH=256 instance with an ideal RAM model.
module tb_ram_bist_ctrl;

`ifdef RAM_BIST_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int D16      = 16;
  localparam int D256     = 256;
  localparam int DONE16   = (NPASS == 2) ? 4 * D16 + 3 : 2 * D16 + 2;
  localparam int DONE256  = (NPASS == 2) ? 4 * D256 + 3 : 2 * D256 + 2;

  logic        clk;
  logic        rst_n;

  logic        start16, start256;
  logic [7:0]  seed16, seed256;
  logic        busy16, done16, pass16, wr16;
  logic        busy256, done256, pass256, wr256;
  logic [15:0] err16, err256;
  logic [7:0]  fail16, fail256, addr16, addr256, wd16, wd256, rd16, rd256;

  logic [7:0]  mem16   [0:255];
  logic [7:0]  and16   [0:255];
  logic [7:0]  or16    [0:255];
  logic [7:0]  mem256  [0:255];

  int n_checks;
  int n_errors;

  ram_bist_ctrl #(.DWIDTH(8), .DEPTH(D16), .AWIDTH(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .seed(seed16),
    .busy(busy16), .done(done16), .pass(pass16), .err_cnt(err16),
    .fail_addr(fail16), .ram_wr_en(wr16), .ram_addr(addr16),
    .ram_wr_data(wd16), .ram_rd_data(rd16)
  );

  ram_bist_ctrl #(.DWIDTH(8), .DEPTH(D256), .AWIDTH(8)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .seed(seed256),
    .busy(busy256), .done(done256), .pass(pass256), .err_cnt(err256),
    .fail_addr(fail256), .ram_wr_en(wr256), .ram_addr(addr256),
    .ram_wr_data(wd256), .ram_rd_data(rd256)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM for the 16-word instance; per-address AND/OR masks model stuck bits
  always @(posedge clk) begin
    if (wr16) mem16[addr16] <= wd16;
    rd16 <= wr16 ? 8'h00 : ((mem16[addr16] & and16[addr16]) | or16[addr16]);
  end

  // ideal RAM for the 256-word instance
  always @(posedge clk) begin
    if (wr256) mem256[addr256] <= wd256;
    rd256 <= wr256 ? 8'h00 : mem256[addr256];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 256; i++) begin
      and16[i] = 8'hFF;
      or16[i]  = 8'h00;
    end
  endtask

  // one full test on the 16-word instance; restart_cyc>0 pulses start again in that cycle
  task automatic run16(input logic [7:0] sd, input int restart_cyc, input logic exp_pass,
                       input logic [15:0] exp_err, input logic [7:0] exp_fail);
    int          busy_first, busy_last, done_cyc, done_cnt;
    logic        pass_d;
    logic [15:0] err_d;
    logic [7:0]  fail_d;
    logic [7:0]  e;
    busy_first = -1; busy_last = -1; done_cyc = -1; done_cnt = 0;
    pass_d = 1'b0; err_d = 16'h0; fail_d = 8'h0;
    @(negedge clk);
    start16 = 1'b1;
    seed16  = sd;
    @(posedge clk);
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      start16 = (k == restart_cyc);
      if (k == 1) check("pass_cleared", 32'(pass16), 32'd0);
      if (k <= D16) begin
        e = sd + 8'(k - 1);
        check("wr_en", 32'(wr16), 32'd1);
        check("wr_addr", 32'(addr16), 32'(k - 1));
        check("wr_data", 32'(wd16), 32'(e));
      end
      if (k == D16 + 1) begin
        check("rd_wr_en", 32'(wr16), 32'd0);
        check("rd_addr0", 32'(addr16), 32'd0);
        check("rd_wdata", 32'(wd16), 32'd0);
      end
`ifdef RAM_BIST_INVERT_PASS_EN
      if (k >= 2 * D16 + 2 && k <= 3 * D16 + 1) begin
        e = ~(sd + 8'(k - 2 * D16 - 2));
        check("wr2_data", 32'(wd16), 32'(e));
      end
`endif
      if (busy16) begin
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (done16) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          pass_d   = pass16;
          err_d    = err16;
          fail_d   = fail16;
        end
      end
      if (done_cyc > 0 && k == done_cyc + 1) begin
        check("done_pulse_len", 32'(done16), 32'd0);
        check("pass_hold", 32'(pass16), 32'(exp_pass));
        check("err_hold", 32'(err16), 32'(exp_err));
        check("fail_hold", 32'(fail16), 32'(exp_fail));
      end
      if (done_cyc > 0 && k >= done_cyc + 3) break;
    end
    start16 = 1'b0;
    check("busy_first", 32'(busy_first), 32'd1);
    check("busy_last", 32'(busy_last), 32'(DONE16 - 1));
    check("done_cycle", 32'(done_cyc), 32'(DONE16));
    check("done_count", 32'(done_cnt), 32'd1);
    check("pass_at_done", 32'(pass_d), 32'(exp_pass));
    check("err_at_done", 32'(err_d), 32'(exp_err));
    check("fail_at_done", 32'(fail_d), 32'(exp_fail));
    check("idle_after", 32'(busy16), 32'd0);
  endtask

  task automatic run256(input logic [7:0] sd);
    int   done_cyc;
    logic pass_d;
    done_cyc = -1;
    pass_d   = 1'b0;
    @(negedge clk);
    start256 = 1'b1;
    seed256  = sd;
    @(posedge clk);
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      start256 = 1'b0;
      if (k == D256) begin
        check("last_wr_en", 32'(wr256), 32'd1);
        check("last_wr_addr", 32'(addr256), 32'hFF);
        check("last_wr_data", 32'(wd256), 32'hFE);
      end
      if (k == D256 + 1) begin
        check("wrap_rd_en", 32'(wr256), 32'd0);
        check("wrap_rd_addr", 32'(addr256), 32'd0);
      end
      if (done256 && done_cyc < 0) begin
        done_cyc = k;
        pass_d   = pass256;
      end
      if (done_cyc > 0) break;
    end
    check("done256_cycle", 32'(done_cyc), 32'(DONE256));
    check("pass256", 32'(pass_d), 32'd1);
    check("err256", 32'(err256), 32'd0);
  endtask

  initial begin
    int done_seen, busy_seen;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start16  = 1'b0;
    start256 = 1'b0;
    seed16   = 8'h00;
    seed256  = 8'h00;
    clear_faults();
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_done", 32'(done16), 32'd0);
    check("rst_pass", 32'(pass16), 32'd0);
    check("rst_err", 32'(err16), 32'd0);
    check("rst_fail", 32'(fail16), 32'd0);
    check("rst_wr_en", 32'(wr16), 32'd0);
    check("rst_addr", 32'(addr16), 32'd0);
    check("rst_wdata", 32'(wd16), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_busy", 32'(busy16), 32'd0);

    // 1: good RAM, seed 5A
    run16(8'h5A, 0, 1'b1, 16'd0, 8'd0);

    // 2: bit0 stuck at 1 on addresses 4 and 10, seed 0 (inverted data has bit0=1 there)
    or16[4]  = 8'h01;
    or16[10] = 8'h01;
    run16(8'h00, 0, 1'b0, 16'd2, 8'd4);
    clear_faults();

    // 3: second start in cycle 8 is ignored
    run16(8'h5A, 8, 1'b1, 16'd0, 8'd0);

    // 4: reset mid-WRITE discards the test
    @(negedge clk);
    start16 = 1'b1;
    seed16  = 8'h33;
    @(posedge clk);
    #1 start16 = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_write_busy", 32'(busy16), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy16), 32'd0);
    check("arst_wr_en", 32'(wr16), 32'd0);
    check("arst_addr", 32'(addr16), 32'd0);
    check("arst_wdata", 32'(wd16), 32'd0);
    check("arst_done", 32'(done16), 32'd0);
    check("arst_pass", 32'(pass16), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done16) done_seen++;
      if (busy16) busy_seen++;
    end
    check("no_done_after_rst", 32'(done_seen), 32'd0);
    check("no_busy_after_rst", 32'(busy_seen), 32'd0);
    run16(8'h33, 0, 1'b1, 16'd0, 8'd0);

    // 5: full address space, counter wrap, seed FF
    run256(8'hFF);

    // 6: bit7 stuck at 0 on address 7 only hurts the inverted pattern (~07 = F8)
    and16[7] = 8'h7F;
    run16(8'h00, 0, (NPASS == 2) ? 1'b0 : 1'b1,
          (NPASS == 2) ? 16'd1 : 16'd0, (NPASS == 2) ? 8'd7 : 8'd0);
    clear_faults();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
